// File: rtl/pulse_stretcher_multi_pkg.sv
// pulse_stretcher_multi_pkg: retrigger mode constants and the CLOG2 helper macro shared by the stretcher files.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
package pulse_stretcher_multi_pkg;
  localparam int PS_MODE_EDGE  = 0;
  localparam int PS_MODE_LEVEL = 1;
endpackage

// File: rtl/pulse_stretcher_multi_if.sv
// pulse_stretcher_multi_if: event inputs, shared hold and stretched outputs of the multi-channel stretcher.
interface pulse_stretcher_multi_if #(
  parameter int CHANNELS = 4,
  parameter int BITS     = 20
);
  logic [CHANNELS-1:0] in;
  logic [BITS-1:0]     hold;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] done;
  modport master (output in, hold, input out, done);
  modport slave  (input in, hold, output out, done);
endinterface

// File: rtl/pulse_stretch_channel.sv
// pulse_stretch_channel: one channel, widens a pulse to at least hold cycles and strobes done as it ends.
module pulse_stretch_channel
  import pulse_stretcher_multi_pkg::*;
#(
  parameter int BITS      = 20,
  parameter int RETRIGGER = PS_MODE_EDGE
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in,
  input  logic [BITS-1:0] hold,
  output logic            out,
  output logic            done
);
  logic [BITS-1:0] rem, rem_next;
  logic            in_prev, load, out_next;
  always_comb begin
    load     = (RETRIGGER == PS_MODE_LEVEL) ? in : (in & ~in_prev & (rem == '0));
    rem_next = load ? hold : (rem != '0) ? rem - BITS'(1) : rem;
    out_next = in | (rem_next != '0);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rem     <= '0;
      in_prev <= 1'b0;
      out     <= 1'b0;
      done    <= 1'b0;
    end else begin
      rem     <= rem_next;
      in_prev <= in;
      out     <= out_next;
      done    <= out & ~out_next;
    end
endmodule

// File: rtl/pulse_stretcher_multi.sv
// pulse_stretcher_multi: CHANNELS independent pulse stretchers sharing one hold value.
// Define PULSE_STRETCH_SYNC_EN to pass each input through a two-flop synchronizer first.
module pulse_stretcher_multi
  import pulse_stretcher_multi_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int BITS      = 20,
  parameter int RETRIGGER = PS_MODE_EDGE
) (
  input logic                    clk,
  input logic                    reset_n,
  pulse_stretcher_multi_if.slave bus
);
  logic [CHANNELS-1:0] in_s;
`ifdef PULSE_STRETCH_SYNC_EN
  logic [CHANNELS-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.in;
      sync2 <= sync1;
    end
  assign in_s = sync2;
`else
  assign in_s = bus.in;
`endif
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pulse_stretch_channel #(.BITS(BITS), .RETRIGGER(RETRIGGER)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .in      (in_s[c]),
      .hold    (bus.hold),
      .out     (bus.out[c]),
      .done    (bus.done[c])
    );
  end
endmodule

// File: tb/tb_pulse_stretcher_multi.sv
// tb_pulse_stretcher_multi: edge and level mode instances against a deadline-based reference model.
module tb_pulse_stretcher_multi;
  import pulse_stretcher_multi_pkg::*;
  localparam int CH = 4;
  localparam int B  = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [CH-1:0] in_v = '0;
  logic [B-1:0]  hold_v = '0;
  int checks = 0;
  int errors = 0;
  int t = 0;
  int end_t [2][CH];
  logic in_prev_m [2][CH];
  logic out_prev_m [2][CH];
  logic [CH-1:0] exp_out [2];
  logic [CH-1:0] exp_done [2];
  logic [CH-1:0] hist [2];
  always #5 clk = ~clk;
  pulse_stretcher_multi_if #(.CHANNELS(CH), .BITS(B)) e_if ();
  pulse_stretcher_multi_if #(.CHANNELS(CH), .BITS(B)) l_if ();
  assign e_if.in = in_v;
  assign e_if.hold = hold_v;
  assign l_if.in = in_v;
  assign l_if.hold = hold_v;
  pulse_stretcher_multi #(.CHANNELS(CH), .BITS(B), .RETRIGGER(PS_MODE_EDGE)) u_edge (
    .clk(clk), .reset_n(reset_n), .bus(e_if));
  pulse_stretcher_multi #(.CHANNELS(CH), .BITS(B), .RETRIGGER(PS_MODE_LEVEL)) u_level (
    .clk(clk), .reset_n(reset_n), .bus(l_if));

  task automatic check(string tag, logic [CH-1:0] got, logic [CH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      exp_out[m] = '0;
      exp_done[m] = '0;
      for (int c = 0; c < CH; c++) begin
        end_t[m][c] = -1;
        in_prev_m[m][c] = 1'b0;
        out_prev_m[m][c] = 1'b0;
      end
    end
    hist[0] = '0;
    hist[1] = '0;
  endtask

  // Output is high through edge end_t-1 after a load at edge t0 (end_t = t0 + hold).
  task automatic model_step();
    logic [CH-1:0] eff;
    logic i, o, trig;
`ifdef PULSE_STRETCH_SYNC_EN
    eff = hist[1];
`else
    eff = in_v;
`endif
    hist[1] = hist[0];
    hist[0] = in_v;
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < CH; c++) begin
        i = eff[c];
        trig = (m == 1) ? i : (i && !in_prev_m[m][c] && end_t[m][c] < t);
        if (trig) end_t[m][c] = t + int'(hold_v);
        o = i || (t < end_t[m][c]);
        exp_out[m][c] = o;
        exp_done[m][c] = out_prev_m[m][c] && !o;
        out_prev_m[m][c] = o;
        in_prev_m[m][c] = i;
      end
    t++;
  endtask

  task automatic check_all(string phase);
    check({phase, "_edge_out"}, e_if.out, exp_out[0]);
    check({phase, "_edge_done"}, e_if.done, exp_done[0]);
    check({phase, "_level_out"}, l_if.out, exp_out[1]);
    check({phase, "_level_done"}, l_if.done, exp_done[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all("run");
  endtask

  task automatic drive(logic [CH-1:0] i, logic [B-1:0] h, int n);
    in_v = i;
    hold_v = h;
    repeat (n) cycle();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;
    drive(4'b0000, 5, 2);
    drive(4'b0001, 5, 1);
    drive(4'b0000, 5, 8);
    drive(4'b0010, 3, 10);
    drive(4'b0000, 3, 5);
    drive(4'b0100, 3, 1);
    drive(4'b0000, 3, 1);
    drive(4'b0100, 3, 1);
    drive(4'b0000, 3, 6);
    drive(4'b1010, 0, 3);
    drive(4'b0101, 0, 2);
    drive(4'b0000, 0, 2);
    drive(4'b0001, 8, 1);
    drive(4'b0000, 8, 1);
    drive(4'b0000, 2, 10);
    drive(4'b1000, 15, 1);
    drive(4'b0000, 15, 18);
    for (int k = 0; k < 600; k++) begin
      logic [CH-1:0] r;
      for (int c = 0; c < CH; c++) r[c] = ($urandom_range(3) == 0);
      if ($urandom_range(15) == 0) hold_v = B'($urandom_range(15));
      drive(r, hold_v, 1);
    end
    drive(4'b0000, 15, 20);
    drive(4'b0001, 15, 1);
    drive(4'b0000, 15, 6);
    in_v = 4'b0011;
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("in_reset");
    reset_n = 1'b1;
    drive(4'b0011, 4, 1);
    drive(4'b0000, 4, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
